// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between UART RX, register file, ALU and TX FIFO.
// Latency: WrEn/RdEn/ALU_EN one cycle after the accepting RX_D_VLD; TX push same cycle FIFO_FULL=0.
// Backpressure: FIFO_FULL holds TX_B0/TX_B1 with TX_P_DATA stable; one command in flight.
//
// Ports: clk, rst_n (async active-low); RX_P_DATA/RX_D_VLD byte input; RdData/RdData_Valid
// regfile read return; ALU_OUT/OUT_Valid ALU result; FIFO_FULL TX backpressure;
// WrEn/RdEn/Address/WrData regfile master; ALU_EN/ALU_FUN/CLK_EN ALU control;
// TX_P_DATA/TX_D_VLD TX FIFO push; busy = not IDLE.
// Optional macro CMD_TIMEOUT_EN: abandon a partial command after TIMEOUT_CYC silent cycles.
module sys_ctrl #(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   RX_P_DATA,
    input  logic            RX_D_VLD,
    input  logic [DW-1:0]   RdData,
    input  logic            RdData_Valid,
    input  logic [2*DW-1:0] ALU_OUT,
    input  logic            OUT_Valid,
    input  logic            FIFO_FULL,
    output logic            WrEn,
    output logic            RdEn,
    output logic [AW-1:0]   Address,
    output logic [DW-1:0]   WrData,
    output logic            ALU_EN,
    output logic [3:0]      ALU_FUN,
    output logic            CLK_EN,
    output logic [DW-1:0]   TX_P_DATA,
    output logic            TX_D_VLD,
    output logic            busy
);

    localparam logic [DW-1:0] CMD_WR   = DW'(8'hAA);
    localparam logic [DW-1:0] CMD_RD   = DW'(8'hBB);
    localparam logic [DW-1:0] CMD_ALU  = DW'(8'hCC);
    localparam logic [DW-1:0] CMD_ALUN = DW'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OPA, OPB, FUNC, ALU_WAIT, TX_B0, TX_B1
    } state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      addr_q, addr_q_nxt;
    logic [2*DW-1:0]    res_q, res_nxt;
    logic               two_byte_q, two_byte_nxt;
    logic               wr_en_nxt, rd_en_nxt, alu_en_nxt;
    logic [AW-1:0]      address_nxt;
    logic [DW-1:0]      wr_data_nxt;
    logic [3:0]         alu_fun_nxt;

`ifdef CMD_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt;
    logic           timed;
    logic           tmo_hit;

    // Only the parser states wait on the host; wait/TX states depend on local blocks.
    assign timed   = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                     (state == OPA) || (state == OPB) || (state == FUNC);
    assign tmo_hit = timed && !RX_D_VLD && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (RX_D_VLD || !timed || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_nxt    = state;
        addr_q_nxt   = addr_q;
        res_nxt      = res_q;
        two_byte_nxt = two_byte_q;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        alu_en_nxt   = 1'b0;
        address_nxt  = Address;
        wr_data_nxt  = WrData;
        alu_fun_nxt  = ALU_FUN;
        case (state)
            IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:   state_nxt = WR_ADDR;
                    CMD_RD:   state_nxt = RD_ADDR;
                    CMD_ALU:  state_nxt = OPA;
                    CMD_ALUN: state_nxt = FUNC;
                    default:  state_nxt = IDLE;
                endcase
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_q_nxt = RX_P_DATA[AW-1:0];
                state_nxt  = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                address_nxt = addr_q;
                wr_data_nxt = RX_P_DATA;
                state_nxt   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                rd_en_nxt   = 1'b1;
                address_nxt = RX_P_DATA[AW-1:0];
                state_nxt   = RD_WAIT;
            end
            RD_WAIT: if (RdData_Valid) begin
                res_nxt      = {{DW{1'b0}}, RdData};
                two_byte_nxt = 1'b0;
                state_nxt    = TX_B0;
            end
            // Operands land in fixed regfile slots 0 and 1 where the ALU reads them.
            OPA: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                address_nxt = AW'(0);
                wr_data_nxt = RX_P_DATA;
                state_nxt   = OPB;
            end
            OPB: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                address_nxt = AW'(1);
                wr_data_nxt = RX_P_DATA;
                state_nxt   = FUNC;
            end
            FUNC: if (RX_D_VLD) begin
                alu_fun_nxt = RX_P_DATA[3:0];
                alu_en_nxt  = 1'b1;
                state_nxt   = ALU_WAIT;
            end
            ALU_WAIT: if (OUT_Valid) begin
                res_nxt      = ALU_OUT;
                two_byte_nxt = 1'b1;
                state_nxt    = TX_B0;
            end
            TX_B0: if (!FIFO_FULL) state_nxt = two_byte_q ? TX_B1 : IDLE;
            TX_B1: if (!FIFO_FULL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef CMD_TIMEOUT_EN
        if (tmo_hit) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            res_q      <= '0;
            two_byte_q <= 1'b0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            ALU_EN     <= 1'b0;
            Address    <= '0;
            WrData     <= '0;
            ALU_FUN    <= '0;
        end else begin
            state      <= state_nxt;
            addr_q     <= addr_q_nxt;
            res_q      <= res_nxt;
            two_byte_q <= two_byte_nxt;
            WrEn       <= wr_en_nxt;
            RdEn       <= rd_en_nxt;
            ALU_EN     <= alu_en_nxt;
            Address    <= address_nxt;
            WrData     <= wr_data_nxt;
            ALU_FUN    <= alu_fun_nxt;
        end
    end

    // Push is gated by the live FIFO_FULL so a byte is never offered into a full FIFO.
    assign TX_D_VLD  = ((state == TX_B0) || (state == TX_B1)) && !FIFO_FULL;
    assign TX_P_DATA = (state == TX_B1) ? res_q[2*DW-1:DW] : res_q[DW-1:0];
    assign CLK_EN    = (state == FUNC) || (state == ALU_WAIT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: scoreboard bench for sys_ctrl; expected strobes queued at stimulus time.
// Latency: monitor compares every WrEn/RdEn/ALU_EN/TX push at negedge against queue head.
// Backpressure: FIFO_FULL driven by stimulus; pushes while full find an empty queue.
module tb_sys_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, busy;
    logic [3:0]  Address, ALU_FUN;
    logic [7:0]  WrData, TX_P_DATA;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];

    localparam logic [7:0] K_WR = 8'd1, K_RD = 8'd2, K_ALU = 8'd3, K_TX = 8'd4;

    sys_ctrl #(.DW(8), .AW(4), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] k, input logic [7:0] a, input logic [7:0] d);
        return {8'h00, k, a, d};
    endfunction

    // Monitor: every strobe must match the oldest expected event; at most one strobe per cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            logic [31:0] obs, exp;
            n = int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(TX_D_VLD);
            if (n > 1) chk("mutex", 32'(n), 32'd1);
            if (n >= 1) begin
                if (WrEn)        obs = ev(K_WR, 8'(Address), WrData);
                else if (RdEn)   obs = ev(K_RD, 8'(Address), 8'h00);
                else if (ALU_EN) obs = ev(K_ALU, 8'h00, 8'(ALU_FUN));
                else             obs = ev(K_TX, 8'h00, TX_P_DATA);
                if (sb.size() == 0) chk("unexpected_strobe", obs, 32'h0);
                else begin
                    exp = sb.pop_front();
                    chk("strobe", obs, exp);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(posedge clk); #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        @(posedge clk); #1;
        RdData = d; RdData_Valid = 1'b1;
        @(posedge clk); #1;
        RdData_Valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        @(posedge clk); #1;
        ALU_OUT = r; OUT_Valid = 1'b1;
        @(posedge clk); #1;
        OUT_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_strobes"}, {28'd0, WrEn, RdEn, ALU_EN, TX_D_VLD}, 32'd0);
        chk({tag, "_busy_clken"}, {30'd0, busy, CLK_EN}, 32'd0);
        chk({tag, "_regs"}, {4'd0, Address, WrData, ALU_FUN, TX_P_DATA}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // Write: AA,05,3C
        sb.push_back(ev(K_WR, 8'h05, 8'h3C));
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_idle("wr_idle", 20);

        // Read: BB,05 then regfile returns 0x3C
        sb.push_back(ev(K_RD, 8'h05, 8'h00));
        send_byte(8'hBB); send_byte(8'h05);
        repeat (3) @(posedge clk);
        @(negedge clk) chk("rd_wait_busy", 32'(busy), 32'd1);
        sb.push_back(ev(K_TX, 8'h00, 8'h3C));
        pulse_rd(8'h3C);
        wait_idle("rd_idle", 20);

        // ALU with operands: CC,12,34,00 -> 0x0046
        sb.push_back(ev(K_WR, 8'h00, 8'h12));
        sb.push_back(ev(K_WR, 8'h01, 8'h34));
        sb.push_back(ev(K_ALU, 8'h00, 8'h00));
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        @(negedge clk) chk("alu_clk_en", 32'(CLK_EN), 32'd1);
        sb.push_back(ev(K_TX, 8'h00, 8'h46));
        sb.push_back(ev(K_TX, 8'h00, 8'h00));
        pulse_alu(16'h0046);
        wait_idle("alu_idle", 20);
        @(negedge clk) chk("idle_clk_en", 32'(CLK_EN), 32'd0);

        // ALU without operands, FIFO full for 10 cycles at the result
        sb.push_back(ev(K_ALU, 8'h00, 8'h02));
        send_byte(8'hDD); send_byte(8'h02);
        @(posedge clk); #1 FIFO_FULL = 1'b1;
        pulse_alu(16'hA55A);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_hold_data", 32'(TX_P_DATA), 32'h5A);
        chk("full_hold_busy", 32'(busy), 32'd1);
        chk("full_sb_drained", 32'(sb.size()), 32'd0);
        sb.push_back(ev(K_TX, 8'h00, 8'h5A));
        sb.push_back(ev(K_TX, 8'h00, 8'hA5));
        @(posedge clk); #1 FIFO_FULL = 1'b0;
        wait_idle("full_idle", 20);

        // Junk byte in IDLE and stray result strobes are ignored
        send_byte(8'h55);
        pulse_rd(8'h99);
        pulse_alu(16'h9999);
        @(negedge clk) chk("junk_busy", 32'(busy), 32'd0);

        // RX bytes during ALU_WAIT are dropped
        sb.push_back(ev(K_ALU, 8'h00, 8'h03));
        send_byte(8'hDD); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'h11);
        @(negedge clk) chk("wait_drop_state", {30'd0, busy, CLK_EN}, 32'd3);
        sb.push_back(ev(K_TX, 8'h00, 8'h88));
        sb.push_back(ev(K_TX, 8'h00, 8'h77));
        pulse_alu(16'h7788);
        wait_idle("wait_drop_idle", 20);

        // Reset mid-CC discards the partial frame
        sb.push_back(ev(K_WR, 8'h00, 8'h12));
        send_byte(8'hCC); send_byte(8'h12);
        @(posedge clk); #1 rst_n = 1'b0;
        check_reset_outputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        send_byte(8'h34);
        @(negedge clk) chk("midrst_after", 32'(busy), 32'd0);

        // Silence after AA,05
        send_byte(8'hAA); send_byte(8'h05);
        repeat (TMO + 5) @(posedge clk);
`ifdef CMD_TIMEOUT_EN
        @(negedge clk) chk("timeout_idle", 32'(busy), 32'd0);
`else
        @(negedge clk) chk("no_timeout_busy", 32'(busy), 32'd1);
        sb.push_back(ev(K_WR, 8'h05, 8'h77));
        send_byte(8'h77);
        wait_idle("late_wr_idle", 20);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk) chk("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
